// File: rtl/tl_pkg.sv
// Shared encodings for the traffic-light lamp guard: lamp one-hot codes, FSM states, fault codes.
// Latency: n/a (declarations and one pure function only).
// Backpressure: n/a.
package tl_pkg;

    // Lamp encodings, bit order {red, green, yellow}
    localparam logic [2:0] LAMP_DARK = 3'b000;
    localparam logic [2:0] LAMP_R    = 3'b100;
    localparam logic [2:0] LAMP_G    = 3'b010;
    localparam logic [2:0] LAMP_Y    = 3'b001;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_PASS  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [1:0] FC_NONE  = 2'd0;
    localparam logic [1:0] FC_MULTI = 2'd1;
    localparam logic [1:0] FC_SEQ   = 2'd2;
    localparam logic [1:0] FC_DARK  = 2'd3;

    // Legal successor in the R->G->Y->R cycle; anything else has no successor.
    function automatic logic [2:0] next_lamp(input logic [2:0] last_lamp);
        case (last_lamp)
            LAMP_R:  next_lamp = LAMP_G;
            LAMP_G:  next_lamp = LAMP_Y;
            LAMP_Y:  next_lamp = LAMP_R;
            default: next_lamp = LAMP_DARK;
        endcase
    endfunction

endpackage

// File: rtl/tl_flasher.sv
// Restartable square-wave generator: out high FLASH_HALF cycles, low FLASH_HALF cycles.
// Latency: restart takes effect on the next edge (out=1, count from 0).
// Backpressure: none; en simply freezes the phase when low.
// Ports: clk, rst_n (async active-low), restart (phase to 1, count to 0),
//        en (advance one cycle), out (current registered phase).
module tl_flasher #(
    parameter int FLASH_HALF = 4,
    parameter int CNT_W      = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic en,
    output logic out
);

    logic [CNT_W-1:0] cnt;
    logic             phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (restart) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (en) begin
            if (cnt == CNT_W'(FLASH_HALF - 1)) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign out = phase;

endmodule

// File: rtl/tl_lamp_guard.sv
// Fail-safe checker between light controller and lamp drivers; faults force flashing red.
// Latency: 2 cycles input-to-lamp (input register, then checked output register).
// Backpressure: none; one sample accepted every cycle, fault held until fault_clr.
// Ports: clk, rst_n (async active-low); red_in/green_in/yellow_in requests; fault_clr pulse;
//        lamp_red/lamp_green/lamp_yellow drives; fault flag; fault_code (first fault latched).
module tl_lamp_guard
    import tl_pkg::*;
#(
    parameter int MIN_DWELL  = 2,
    parameter int DARK_MAX   = 3,
    parameter int FLASH_HALF = 4,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       red_in,
    input  logic       green_in,
    input  logic       yellow_in,
    input  logic       fault_clr,
    output logic       lamp_red,
    output logic       lamp_green,
    output logic       lamp_yellow,
    output logic       fault,
    output logic [1:0] fault_code
);

    state_t           state, state_nxt;
    logic [2:0]       in_q;
    logic [2:0]       last_lamp, last_nxt;
    logic [CNT_W-1:0] dwell, dwell_nxt, dwell_inc;
    logic [CNT_W-1:0] dark, dark_nxt, dark_inc;
    logic [2:0]       lamps_q, lamps_nxt;
    logic [1:0]       code_q, code_nxt;
    logic             is_single, is_multi;
    logic             flash_restart, flash_out;

    // Stage 1: raw request sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) in_q <= LAMP_DARK;
        else        in_q <= {red_in, green_in, yellow_in};
    end

    assign is_single = (in_q == LAMP_R) || (in_q == LAMP_G) || (in_q == LAMP_Y);
    assign is_multi  = !is_single && (in_q != LAMP_DARK);
    // Dwell saturates so a long-held lamp never wraps back below MIN_DWELL.
    assign dwell_inc = (dwell >= CNT_W'(MIN_DWELL)) ? dwell : dwell + 1'b1;
    assign dark_inc  = dark + 1'b1;

    always_comb begin
        state_nxt = state;
        last_nxt  = last_lamp;
        dwell_nxt = dwell;
        dark_nxt  = dark;
        lamps_nxt = lamps_q;
        code_nxt  = code_q;
        case (state)
            ST_INIT: begin
                lamps_nxt = LAMP_R;
                if (is_multi) begin
                    state_nxt = ST_FAULT;
                    code_nxt  = FC_MULTI;
                end else if (in_q == LAMP_R) begin
                    state_nxt = ST_PASS;
                    last_nxt  = LAMP_R;
                    dwell_nxt = CNT_W'(1);
                    dark_nxt  = '0;
                end
            end
            ST_PASS: begin
                if (is_multi) begin
                    state_nxt = ST_FAULT;
                    code_nxt  = FC_MULTI;
                end else if (in_q == LAMP_DARK) begin
                    dwell_nxt = dwell_inc;
                    dark_nxt  = dark_inc;
                    if (dark_inc > CNT_W'(DARK_MAX)) begin
                        state_nxt = ST_FAULT;
                        code_nxt  = FC_DARK;
                    end else begin
                        lamps_nxt = last_lamp;
                    end
                end else if (in_q == last_lamp) begin
                    lamps_nxt = in_q;
                    dwell_nxt = dwell_inc;
                    dark_nxt  = '0;
                end else if ((in_q == next_lamp(last_lamp)) &&
                             (dwell >= CNT_W'(MIN_DWELL))) begin
                    lamps_nxt = in_q;
                    last_nxt  = in_q;
                    dwell_nxt = CNT_W'(1);
                    dark_nxt  = '0;
                end else begin
                    state_nxt = ST_FAULT;
                    code_nxt  = FC_SEQ;
                end
            end
            ST_FAULT: begin
                // Violations are ignored here; only fault_clr leaves.
                if (fault_clr) begin
                    state_nxt = ST_INIT;
                    code_nxt  = FC_NONE;
                    last_nxt  = LAMP_DARK;
                    dwell_nxt = '0;
                    dark_nxt  = '0;
                    lamps_nxt = LAMP_R;
                end
            end
            default: begin
                state_nxt = ST_INIT;
                lamps_nxt = LAMP_R;
            end
        endcase
        // Green/yellow are dark for the whole fault; red comes from the flasher.
        if (state_nxt == ST_FAULT) lamps_nxt = LAMP_R;
    end

    assign flash_restart = (state != ST_FAULT) && (state_nxt == ST_FAULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            last_lamp <= LAMP_DARK;
            dwell     <= '0;
            dark      <= '0;
            lamps_q   <= LAMP_R;
            code_q    <= FC_NONE;
        end else begin
            state     <= state_nxt;
            last_lamp <= last_nxt;
            dwell     <= dwell_nxt;
            dark      <= dark_nxt;
            lamps_q   <= lamps_nxt;
            code_q    <= code_nxt;
        end
    end

    tl_flasher #(
        .FLASH_HALF (FLASH_HALF),
        .CNT_W      (CNT_W)
    ) u_flasher (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (flash_restart),
        .en      (state == ST_FAULT),
        .out     (flash_out)
    );

    // Both mux inputs and the select are flops, so red stays a registered drive.
    assign lamp_red    = (state == ST_FAULT) ? flash_out : lamps_q[2];
    assign lamp_green  = lamps_q[1];
    assign lamp_yellow = lamps_q[0];
    assign fault       = (state == ST_FAULT);
    assign fault_code  = code_q;

endmodule
